// File: rtl/inner_product_pkg.sv
// rtl/inner_product_pkg.sv - shared types and arithmetic helpers for the inner_product neuron
package inner_product_pkg;

    typedef enum logic [3:0] {INI, ARG, MAC, ACC, RES, DEL, ERR, PRP, UPD} state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int SAT_W = 64;
    typedef logic signed [SAT_W-1:0] wide_t;

    // Clamp a wide signed value to the r-bit two's complement range; callers truncate to r bits.
    function automatic wide_t sat(input wide_t x, input int r);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (r - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (r - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int acc_width(input int r, input int w, input int n);
        return r + w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/inner_product_if.sv
// rtl/inner_product_if.sv - argument, result, error and propagate handshakes of inner_product
interface inner_product_if #(
    parameter int N = 2,
    parameter int W = 8,
    parameter int R = 16
);
    logic                  train;
    logic                  argument_valid;
    logic                  argument_ready;
    logic [N*W-1:0]        argument_data;
    logic                  result_valid;
    logic                  result_ready;
    logic [R-1:0]          result_data;
    logic                  error_valid;
    logic                  error_ready;
    logic signed [R-1:0]   error_data;
    logic                  propagate_valid;
    logic                  propagate_ready;
    logic [N*R-1:0]        propagate_data;

    modport master (
        output train, argument_valid, argument_data, result_ready,
               error_valid, error_data, propagate_ready,
        input  argument_ready, result_valid, result_data, error_ready,
               propagate_valid, propagate_data
    );

    modport slave (
        input  train, argument_valid, argument_data, result_ready,
               error_valid, error_data, propagate_ready,
        output argument_ready, result_valid, result_data, error_ready,
               propagate_valid, propagate_data
    );
endinterface

// File: rtl/inner_product_lfsr16.sv
// rtl/inner_product_lfsr16.sv - 16-bit right-shifting Galois LFSR used for weight initialisation
module lfsr16
    import inner_product_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // An all-zero state would lock up, so a zero seed is replaced by 1.
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= (seed == 16'h0000) ? 16'h0001 : seed;
        else       lfsr_q <= lfsr_d;
    end

    assign state = lfsr_q;
endmodule

// File: rtl/inner_product.sv
// rtl/inner_product.sv - trainable single-neuron inner product with saturating arithmetic
// and LFSR weight initialisation after every reset.
module inner_product
    import inner_product_pkg::*;
#(
    parameter int          N    = 2,
    parameter int          W    = 8,
    parameter int          R    = 16,
    parameter int          F    = 8,
    parameter int          S    = 2,
    parameter logic [15:0] SEED = 16'd1
) (
    input  logic           clock,
    input  logic           reset,
    inner_product_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int PW = R + W + 1;
    localparam int EW = 2 * R;
    localparam int AW = acc_width(R, W, N);

    function automatic logic signed [R-1:0] sat_r(input wide_t x);
        return R'(sat(x, R));
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [R-1:0]  bias_q, bias_d;
    logic signed [R-1:0]  result_q, result_d;
    logic [N*R-1:0]       prop_q, prop_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [PW-1:0] summand_q, summand_d;
    logic signed [R-1:0]  delta_q, delta_d;
    logic [W-1:0]         arg_q [N];
    logic [W-1:0]         arg_d [N];
    logic signed [R-1:0]  weight_q [N];
    logic signed [R-1:0]  weight_d [N];
    logic signed [R-1:0]  term_q [N];
    logic signed [R-1:0]  term_d [N];

    logic [15:0]          lfsr_state;
    logic                 lfsr_advance;
    logic                 unused_lfsr;
    logic signed [R-1:0]  w_cur, err_in;
    logic [W-1:0]         a_cur;
    logic signed [PW-1:0] wa_prod, da_prod;
    logic signed [EW-1:0] wd_prod;
    logic                 last;

    lfsr16 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .seed    (SEED),
        .advance (lfsr_advance),
        .state   (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state[15:F-3];

    // Full-width products; the unsigned argument is zero-extended before the signed multiply.
    assign w_cur   = weight_q[cnt_q];
    assign a_cur   = arg_q[cnt_q];
    assign err_in  = bus.error_data;
    assign wa_prod = PW'(w_cur) * $signed(PW'(a_cur));
    assign da_prod = PW'(delta_q) * $signed(PW'(a_cur));
    assign wd_prod = EW'(w_cur) * EW'(delta_q);
    assign last    = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bias_d       = bias_q;
        result_d     = result_q;
        prop_d       = prop_q;
        acc_d        = acc_q;
        summand_d    = summand_q;
        delta_d      = delta_q;
        arg_d        = arg_q;
        weight_d     = weight_q;
        term_d       = term_q;
        lfsr_advance = 1'b0;

        case (state_q)
            INI: begin
                weight_d[cnt_q] = R'($signed(lfsr_state[F-4:0]));
                lfsr_advance    = 1'b1;
                cnt_d           = last ? '0 : cnt_q + CW'(1);
                if (last) state_d = ARG;
            end
            ARG: begin
                if (bus.argument_valid) begin
                    for (int i = 0; i < N; i++) arg_d[i] = bus.argument_data[i*W +: W];
                    acc_d   = AW'(bias_q);
                    state_d = MAC;
                end
            end
            MAC: begin
                // The summand lags one cycle; the final one is folded in by ACC.
                summand_d = wa_prod >>> F;
                if (cnt_q != '0) acc_d = acc_q + AW'(summand_q);
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (last) state_d = ACC;
            end
            ACC: begin
                result_d = sat_r(wide_t'(acc_q + AW'(summand_q)));
                state_d  = RES;
            end
            RES: begin
                if (bus.result_ready) state_d = bus.train ? DEL : ARG;
            end
            DEL: begin
                if (bus.error_valid) begin
                    delta_d = err_in;
                    bias_d  = sat_r(wide_t'(bias_q) + wide_t'(err_in >>> S));
                    state_d = ERR;
                end
            end
            ERR: begin
                term_d[cnt_q] = sat_r(wide_t'(wd_prod >>> F));
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    for (int i = 0; i < N; i++) prop_d[i*R +: R] = term_d[i];
                    state_d = PRP;
                end
            end
            PRP: begin
                if (bus.propagate_ready) state_d = UPD;
            end
            UPD: begin
                weight_d[cnt_q] = sat_r(wide_t'(w_cur) + wide_t'(da_prod >>> (F + S)));
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (last) state_d = ARG;
            end
            default: begin
                state_d = INI;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= INI;
            cnt_q    <= '0;
            bias_q   <= '0;
            result_q <= '0;
            prop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bias_q   <= bias_d;
            result_q <= result_d;
            prop_q   <= prop_d;
        end
    end

    // Datapath registers are always written before use, so they carry no reset.
    always_ff @(posedge clock) begin
        acc_q     <= acc_d;
        summand_q <= summand_d;
        delta_q   <= delta_d;
        arg_q     <= arg_d;
        weight_q  <= weight_d;
        term_q    <= term_d;
    end

    assign bus.argument_ready  = (state_q == ARG);
    assign bus.result_valid    = (state_q == RES);
    assign bus.result_data     = result_q;
    assign bus.error_ready     = (state_q == DEL);
    assign bus.propagate_valid = (state_q == PRP);
    assign bus.propagate_data  = prop_q;
endmodule

// File: doc/inner_product.md
# inner_product

Parametrised, trainable single-neuron inner product for the machina datapath: computes bias + Σ weight[n]·argument[n] over N channels with configurable argument width, weight width and fixed-point scaling. Sits between an argument producer and an activation stage. When training, it accepts an error delta, back-propagates per-channel error terms and updates weights and bias. Adds two behaviours over the previous generation: saturating arithmetic, and a deterministic LFSR weight initialisation that re-runs on every reset.

## Interface
- N, 2: channel count (≥2)
- W, 8: argument width, unsigned
- R, 16: weight/bias/result/error width, signed two's complement
- F, 8: fraction bits of weights, deltas and results
- S, 2: learning-rate shift (rate = 2^-S)
- SEED, 1: 16-bit LFSR seed; 0 is replaced by 1
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- train  in  1  mode select, sampled at result handshake
- argument_valid/argument_ready  in/out  1/1  argument handshake
- argument_data  in  N×W  packed channel arguments, channel 0 in LSBs
- result_valid/result_ready  out/in  1/1  result handshake
- result_data  out  R  saturated inner product
- error_valid/error_ready  in/out  1/1  delta handshake
- error_data  in  R  signed delta
- propagate_valid/propagate_ready  out/in  1/1  error-term handshake
- propagate_data  out  N×R  per-channel error terms

## Operation
- All handshakes: transfer on a cycle with valid & ready both high. Sources hold valid and data stable until transfer.
- States: INI, ARG, MAC, ACC, RES, DEL, ERR, PRP, UPD. Channel counter runs 0..N-1 in INI, MAC, ERR, UPD and wraps to 0.
- INI (N cycles): weight[k] ← sign-extended lfsr[F-4:0]. Then the LFSR advances (16-bit Galois, right shift, taps 0xB400). → ARG.
- ARG: argument_ready=1. On transfer: latch arguments, accumulator ← bias → MAC.
- MAC (N cycles): summand ← (weight[k]·arg[k]) >>> F. Accumulator adds the previous summand (not on k=0). After k=N-1 → ACC.
- ACC: result_data ← sat_R(accumulator + summand), result_valid ← 1 → RES.
- RES: hold until transfer. Then → DEL if train, else → ARG.
- DEL: error_ready=1. On transfer: delta ← error_data, bias ← sat_R(bias + (delta >>> S)) → ERR.
- ERR (N cycles): term[k] ← sat_R((weight[k]·delta) >>> F).
- ERR exit: propagate_data ← terms, propagate_valid ← 1 → PRP.
- PRP: hold until transfer → UPD.
- UPD (N cycles): weight[k] ← sat_R(weight[k] + ((delta·arg[k]) >>> (F+S))).
- UPD exit: → ARG.
- Arithmetic: products formed at full width (R+W+1 or 2R bits), arithmetic right shift (floor). Accumulator is R+W+clog2(N)+1 bits and never wraps. sat_R clamps to [-2^(R-1), 2^(R-1)-1].

## Timing
- Reset (any state, including mid-handshake): state→INI, counter 0, bias 0, LFSR←SEED.
- Reset values: all valid/ready outputs 0, result_data 0, propagate_data 0. Weights are reloaded during INI.
- argument_ready first rises N cycles after reset deasserts.
- Latency: result_valid rises N+1 cycles after the argument transfer edge.
- Latency: propagate_valid rises N cycles after the error transfer edge.
- Inference throughput: one result per N+3 cycles with ready held high.
- result_data and propagate_data are stable while their valid is high.
- ready never depends combinationally on valid.
- train is ignored outside the RES transfer cycle.
- argument_valid is ignored outside ARG; error_valid is ignored outside DEL.

## Structure
- Package inner_product_pkg holds:
  - state_t enum
  - LFSR taps constant 0xB400
  - parametrised sat function
  - accumulator-width helper
- Sub-module lfsr16 (seed, advance, state output) is instantiated once.
- Weights are held in an N-entry register array indexed by the counter.

## Test plan
Parameters for all scenarios: N=2, W=8, R=16, F=8, S=2, SEED=1.
- Reset/init: pulse reset mid-MAC → all outputs 0, argument_ready low 2 cycles then high. Weights are (1, 0); verify in the training scenario.
- Inference latency: args (0,0), train=0 → result_data 0. result_valid rises 3 cycles after the transfer edge.
- Training: args (0,0), train=1, delta 256 → propagate_data (1, 0). Bias 64. Next args (0,0) → result 64.
- Weight update: fresh reset, args (255,0), train=1, delta 1024 → w0=256, bias 256. Next args (255,0) → result 511.
- Saturation: five trainings with args (0,0), delta 32767. Bias goes 8191 → … → 32764 → 32767 (clamped). Result 32767; never wraps negative.
- Back-pressure: hold result_ready low 5 cycles, then propagate_ready low 5 cycles → valid and data stable throughout, no other ready asserted, and the handshake completes on release.
